// File: rtl/point_link_pkg.sv
`default_nettype none
//==============================================================================
// Module   : point_link_pkg
// Purpose  : Shared types and helpers for the master side of the point link.
//            Holds the link FSM state encoding and the FIFO occupancy-width
//            helper so the top level and the FIFO agree on counter sizing.
// Revision : 1.0  initial release
//==============================================================================
package point_link_pkg;

   // Link bring-up state: quiet settle phase after reset, then normal traffic.
   typedef enum logic [0:0] {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } link_state_t;

   // Occupancy counter must represent 0..depth inclusive, hence the +1.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/point_fifo.sv
`default_nettype none
//==============================================================================
// Module   : point_fifo
// Purpose  : Synchronous FIFO with first-word fall-through read port. The
//            head word is always visible on dout while the FIFO is non-empty.
//            Pushes while full and pops while empty are ignored.
// Ports    : clock, reset (async, active-high)
//            push, din            - write strobe and data
//            pop,  dout           - read strobe and head-of-queue data
//            count, full, empty   - occupancy status
// Revision : 1.0  initial release
//==============================================================================
module point_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: only words that were written are ever read out.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/point_master_link.sv
`default_nettype none
//==============================================================================
// Module   : point_master_link
// Purpose  : Master-side endpoint of the point-to-point link. Local words are
//            queued in a TX FIFO and driven onto the link through a registered
//            data_o stage with stall-based flow control. Words returned by the
//            slave are captured into a one-entry holding register. After reset
//            the link is held quiet for SETTLE_CYCLES cycles.
// Ports    : clock, reset          - sole clock, async active-high reset
//            tx_valid/tx_ready/tx_data, tx_count  - local TX stream + occupancy
//            data_o, data_o_valid, stall_i        - link toward slave
//            data_i, data_i_valid, stall_o        - link from slave
//            rx_valid/rx_ready/rx_data, rx_overflow - local RX stream + sticky
// Revision : 1.0  initial release
//==============================================================================
module point_master_link
   import point_link_pkg::*;
#(
   parameter int WIDTH_O       = 8,
   parameter int WIDTH_I       = 8,
   parameter int DEPTH         = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   input  logic [WIDTH_O-1:0]     tx_data,
   output logic [$clog2(DEPTH):0] tx_count,
   output logic [WIDTH_O-1:0]     data_o,
   output logic                   data_o_valid,
   input  logic                   stall_i,
   input  logic [WIDTH_I-1:0]     data_i,
   input  logic                   data_i_valid,
   output logic                   stall_o,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic [WIDTH_I-1:0]     rx_data,
   output logic                   rx_overflow
);

   localparam int CNT_W = count_width(DEPTH);
   localparam int SW    = $clog2(SETTLE_CYCLES + 1);

   //---------------------------------------------------------------------------
   // Settle FSM
   //---------------------------------------------------------------------------
   link_state_t   state;
   link_state_t   state_next;
   logic [SW-1:0] settle_cnt;
   logic [SW-1:0] settle_cnt_next;
   logic          run;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= SETTLE;
         settle_cnt <= SW'(SETTLE_CYCLES - 1);
      end else begin
         state      <= state_next;
         settle_cnt <= settle_cnt_next;
      end
   end

   always_comb begin
      state_next      = state;
      settle_cnt_next = settle_cnt;
      case (state)
         SETTLE: begin
            if (settle_cnt == '0) state_next = RUN;
            else                  settle_cnt_next = settle_cnt - 1'b1;
         end
         RUN:     state_next = RUN;
         default: state_next = SETTLE;
      endcase
   end

   assign run = (state == RUN);

   //---------------------------------------------------------------------------
   // TX path: FIFO feeding the registered link stage
   //---------------------------------------------------------------------------
   logic [CNT_W-1:0]   fifo_count;
   logic [WIDTH_O-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;

   // Depends only on state and occupancy, never on tx_valid; a full FIFO
   // refuses even when a pop happens in the same cycle.
   assign tx_ready  = run && !fifo_full;
   assign fifo_push = tx_valid && tx_ready;

   // The link stage can accept a new word when it is empty or its current
   // word is being taken by the slave this cycle.
   assign fifo_pop  = run && !fifo_empty && (!data_o_valid || !stall_i);

   assign tx_count  = fifo_count;

   point_fifo #(
      .WIDTH (WIDTH_O),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_o       <= '0;
         data_o_valid <= 1'b0;
      end else if (fifo_pop) begin
         data_o       <= fifo_dout;
         data_o_valid <= 1'b1;
      end else if (data_o_valid && !stall_i) begin
         // Word consumed with nothing behind it; data_o keeps its last value.
         data_o_valid <= 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // RX path: one-entry holding register with sticky overflow
   //---------------------------------------------------------------------------
   logic               rx_valid_next;
   logic [WIDTH_I-1:0] rx_data_next;
   logic               rx_overflow_next;
   logic               stall_o_next;

   always_comb begin
      rx_valid_next    = rx_valid;
      rx_data_next     = rx_data;
      rx_overflow_next = rx_overflow;
      if (run) begin
         if (data_i_valid) begin
            if (!rx_valid || rx_ready) begin
               rx_data_next  = data_i;
               rx_valid_next = 1'b1;
            end else begin
               // Holding register occupied and not drained: word is lost.
               rx_overflow_next = 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid_next = 1'b0;
         end
      end
      // Looks at the state being entered so the slave is released on the
      // very first RUN cycle rather than one cycle later.
      stall_o_next = (state_next == RUN) ? (rx_valid_next && !rx_ready) : 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         rx_overflow <= 1'b0;
         stall_o     <= 1'b1;
      end else begin
         rx_valid    <= rx_valid_next;
         rx_data     <= rx_data_next;
         rx_overflow <= rx_overflow_next;
         stall_o     <= stall_o_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_point_master_link.sv
`default_nettype none
//==============================================================================
// Module   : tb_point_master_link
// Purpose  : Self-checking bench for point_master_link. A queue-based model of
//            the link endpoint runs alongside the DUT every cycle; directed
//            table rows and hand-written sequences add explicit expectations.
// Revision : 1.0  initial release
//==============================================================================
module tb_point_master_link;

   localparam int WIDTH_O       = 8;
   localparam int WIDTH_I       = 8;
   localparam int DEPTH         = 4;
   localparam int SETTLE_CYCLES = 4;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   tx_valid;
   logic                   tx_ready;
   logic [WIDTH_O-1:0]     tx_data;
   logic [$clog2(DEPTH):0] tx_count;
   logic [WIDTH_O-1:0]     data_o;
   logic                   data_o_valid;
   logic                   stall_i;
   logic [WIDTH_I-1:0]     data_i;
   logic                   data_i_valid;
   logic                   stall_o;
   logic                   rx_valid;
   logic                   rx_ready;
   logic [WIDTH_I-1:0]     rx_data;
   logic                   rx_overflow;

   always #5 clock = ~clock;

   point_master_link #(
      .WIDTH_O       (WIDTH_O),
      .WIDTH_I       (WIDTH_I),
      .DEPTH         (DEPTH),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .tx_count     (tx_count),
      .data_o       (data_o),
      .data_o_valid (data_o_valid),
      .stall_i      (stall_i),
      .data_i       (data_i),
      .data_i_valid (data_i_valid),
      .stall_o      (stall_o),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .rx_overflow  (rx_overflow)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model state
   logic [7:0] m_q [$];
   logic [7:0] m_do;
   logic       m_dov;
   logic       m_rxv;
   logic [7:0] m_rxd;
   logic       m_ovf;
   logic       m_stall;
   int         m_edges;

   logic [7:0] taken [$];
   logic [7:0] words [6];

   typedef struct {
      logic       tv;
      logic [7:0] td;
      logic       div;
      logic [7:0] di;
      logic       e_rdy;
      logic [2:0] e_cnt;
      logic [7:0] e_do;
      logic       e_dov;
      logic       e_stall;
      logic       e_rxv;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_ready();
      return (m_edges >= SETTLE_CYCLES) && (m_q.size() < DEPTH);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_do    = 8'h00;
      m_dov   = 1'b0;
      m_rxv   = 1'b0;
      m_rxd   = 8'h00;
      m_ovf   = 1'b0;
      m_stall = 1'b1;
      m_edges = 0;
   endtask

   // One clock edge of the endpoint, from its rules: queue, link register, RX.
   task automatic model_edge();
      logic run;
      logic psh;
      logic pp;
      run = (m_edges >= SETTLE_CYCLES);
      psh = tx_valid && m_ready();
      pp  = run && (m_q.size() > 0) && (!m_dov || !stall_i);
      if (pp) begin
         m_do  = m_q.pop_front();
         m_dov = 1'b1;
      end else if (m_dov && !stall_i) begin
         m_dov = 1'b0;
      end
      if (psh) m_q.push_back(tx_data);
      if (run) begin
         if (data_i_valid) begin
            if (!m_rxv || rx_ready) begin
               m_rxd = data_i;
               m_rxv = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end else if (m_rxv && rx_ready) begin
            m_rxv = 1'b0;
         end
      end
      m_edges++;
      m_stall = (m_edges >= SETTLE_CYCLES) ? (m_rxv && !rx_ready) : 1'b1;
   endtask

   task automatic check_model();
      chk("tx_ready",     tx_ready,     m_ready());
      chk("tx_count",     tx_count,     m_q.size());
      chk("data_o",       data_o,       m_do);
      chk("data_o_valid", data_o_valid, m_dov);
      chk("stall_o",      stall_o,      m_stall);
      chk("rx_valid",     rx_valid,     m_rxv);
      chk("rx_data",      rx_data,      m_rxd);
      chk("rx_overflow",  rx_overflow,  m_ovf);
   endtask

   // Called at posedge+1; drives inputs, logs any word the slave takes at the
   // coming edge, then checks against the model just after that edge.
   task automatic cycle(input logic tv, input logic [7:0] td, input logic st,
                        input logic div, input logic [7:0] di, input logic rr);
      tx_valid     = tv;
      tx_data      = td;
      stall_i      = st;
      data_i_valid = div;
      data_i       = di;
      rx_ready     = rr;
      if (data_o_valid === 1'b1 && st == 1'b0) taken.push_back(data_o);
      @(posedge clock);
      model_edge();
      #1;
      check_model();
   endtask

   // Asserts reset mid-cycle and checks the asynchronous clear immediately.
   task automatic do_reset(input logic tv);
      #2;
      tx_valid     = tv;
      tx_data      = 8'h11;
      stall_i      = 1'b0;
      data_i_valid = 1'b0;
      data_i       = 8'h00;
      rx_ready     = 1'b1;
      reset        = 1'b1;
      #1;
      chk("rst tx_count",     tx_count,     0);
      chk("rst tx_ready",     tx_ready,     0);
      chk("rst data_o",       data_o,       0);
      chk("rst data_o_valid", data_o_valid, 0);
      chk("rst stall_o",      stall_o,      1);
      chk("rst rx_valid",     rx_valid,     0);
      chk("rst rx_data",      rx_data,      0);
      chk("rst rx_overflow",  rx_overflow,  0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int guard;
      logic acc;

      reset = 1'b0;
      words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

      // Settle with tx_valid held high, then 0x11/0x22/0x33 back to back.
      tbl[0] = '{1'b1, 8'h11, 1'b1, 8'hEE, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'h11, 1'b1, 8'hEE, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 3'd1, 8'h11, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 3'd1, 8'h22, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 8'h33, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 8'h33, 1'b0, 1'b0, 1'b0};

      @(posedge clock);
      #1;
      do_reset(1'b1);

      taken.delete();
      foreach (tbl[i]) begin
         cycle(tbl[i].tv, tbl[i].td, 1'b0, tbl[i].div, tbl[i].di, 1'b1);
         chk($sformatf("row%0d tx_ready", i),     tx_ready,     tbl[i].e_rdy);
         chk($sformatf("row%0d tx_count", i),     tx_count,     tbl[i].e_cnt);
         chk($sformatf("row%0d data_o", i),       data_o,       tbl[i].e_do);
         chk($sformatf("row%0d data_o_valid", i), data_o_valid, tbl[i].e_dov);
         chk($sformatf("row%0d stall_o", i),      stall_o,      tbl[i].e_stall);
         chk($sformatf("row%0d rx_valid", i),     rx_valid,     tbl[i].e_rxv);
      end
      chk("b2b taken count", taken.size(), 3);
      if (taken.size() == 3) begin
         chk("b2b word0", taken[0], 8'h11);
         chk("b2b word1", taken[1], 8'h22);
         chk("b2b word2", taken[2], 8'h33);
      end

      // Stalled link: five words pushed, one sits in data_o, four fill the FIFO.
      taken.delete();
      k = 0;
      guard = 0;
      while (k < 5 && guard < 20) begin
         acc = m_ready();
         cycle(1'b1, words[k], 1'b1, 1'b0, 8'h00, 1'b1);
         if (acc) k++;
         guard++;
      end
      chk("stall pushes accepted", k, 5);
      chk("stall data_o", data_o, 8'hA1);
      chk("stall tx_count", tx_count, 4);
      chk("stall tx_ready", tx_ready, 0);
      cycle(1'b1, words[5], 1'b1, 1'b0, 8'h00, 1'b1);
      chk("stall hold data_o", data_o, 8'hA1);
      chk("stall hold count", tx_count, 4);

      // Full FIFO: push refused on the pop cycle, accepted on the next one.
      cycle(1'b1, words[5], 1'b0, 1'b0, 8'h00, 1'b1);
      chk("full pop count", tx_count, 3);
      chk("full pop data_o", data_o, 8'hB2);
      cycle(1'b1, words[5], 1'b1, 1'b0, 8'h00, 1'b1);
      chk("full refill count", tx_count, 4);
      chk("full refill ready", tx_ready, 0);
      repeat (8) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain taken count", taken.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < taken.size()) chk($sformatf("drain word%0d", i), taken[i], words[i]);
      end

      // RX overflow: second word dropped while the first is not taken.
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
      chk("rx first valid", rx_valid, 1);
      chk("rx first data", rx_data, 8'hA5);
      chk("rx first stall", stall_o, 1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0);
      chk("rx ovf data", rx_data, 8'hA5);
      chk("rx ovf flag", rx_overflow, 1);
      chk("rx ovf stall", stall_o, 1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("rx drained valid", rx_valid, 0);
      chk("rx sticky ovf", rx_overflow, 1);
      chk("rx drained stall", stall_o, 0);

      // Reset mid-operation with three words queued and data_o occupied.
      for (int i = 0; i < 4; i++) cycle(1'b1, words[i], 1'b1, 1'b0, 8'h00, 1'b1);
      chk("pre-reset count", tx_count, 3);
      chk("pre-reset valid", data_o_valid, 1);
      do_reset(1'b0);
      taken.delete();
      repeat (10) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("post-reset no stale word", taken.size(), 0);
      chk("post-reset data_o_valid", data_o_valid, 0);

      // Randomized traffic checked against the model every cycle.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom),
               (i < 200) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 2) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/point_master_link.md
# point_master_link

Synthesizable master-side endpoint of the point-to-point link; the counterpart to the slave I/O transactor at the far end. It accepts words from local logic on a valid/ready stream, buffers them in a FIFO, and drives them onto the link with stall-based flow control. It also captures words returned by the slave into a one-entry holding register for local logic. A post-reset settle phase keeps the link quiet until both ends have stable initial values.

## Interface
- WIDTH_O, 8: master→slave payload width, ≥1
- WIDTH_I, 8: slave→master payload width, ≥1
- DEPTH, 4: TX FIFO depth, power of two, ≥2
- SETTLE_CYCLES, 4: idle cycles after reset before link traffic, ≥1
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- tx_valid  input  1  local word offered
- tx_ready  output  1  FIFO can accept (count < DEPTH)
- tx_data  input  WIDTH_O  local word
- tx_count  output  $clog2(DEPTH)+1  FIFO occupancy
- data_o  output  WIDTH_O  link word to slave, registered
- data_o_valid  output  1  data_o holds a word, registered
- stall_i  input  1  slave cannot take data_o this cycle
- data_i  input  WIDTH_I  link word from slave
- data_i_valid  input  1  data_i valid this cycle
- stall_o  output  1  master cannot take data_i, registered
- rx_valid  output  1  rx_data holds a word
- rx_ready  input  1  local logic takes rx_data
- rx_data  output  WIDTH_I  received word
- rx_overflow  output  1  sticky: slave word dropped

## Operation
- Reset values: tx_count=0, tx_ready=0 (during SETTLE), data_o=0, data_o_valid=0, stall_o=1, rx_valid=0, rx_data=0, rx_overflow=0, state=SETTLE, settle counter=SETTLE_CYCLES-1.
- FSM: SETTLE → RUN when the counter reaches 0; otherwise decrement each cycle. RUN is held until reset. In SETTLE: tx_ready=0, stall_o=1, data_i_valid ignored.
- TX push: tx_valid && tx_ready at an edge writes tx_data to the FIFO. When full, tx_ready=0 even if a pop occurs in the same cycle.
- TX pop/load occurs at an edge when state=RUN, FIFO is non-empty, and (!data_o_valid || !stall_i). The FIFO head loads into data_o and data_o_valid=1.
- TX drain occurs when data_o_valid && !stall_i and the FIFO is empty: data_o_valid→0 and data_o keeps its last value.
- While stall_i=1 and data_o_valid=1, data_o and data_o_valid hold stable.
- Simultaneous push and pop leaves tx_count unchanged. FIFO pointers wrap modulo DEPTH.
- RX capture occurs in RUN when data_i_valid=1 and (!rx_valid || rx_ready): rx_data←data_i and rx_valid=1.
- When data_i_valid=0 and rx_valid && rx_ready: rx_valid→0.
- RX overflow: data_i_valid=1 while rx_valid && !rx_ready. The word is dropped, rx_data is unchanged, and rx_overflow→1 until reset.
- stall_o is registered as (next rx_valid && !rx_ready) in RUN, and 1 in SETTLE.

## Timing
- tx_ready depends combinationally on count and state only. There is no path from tx_valid to tx_ready.
- Push at edge N with the FIFO empty and the link idle: data_o_valid=1 after edge N+1. Fall-through latency is 1 cycle.
- Back-to-back throughput is 1 word per cycle while stall_i=0.
- A stall_i rise takes effect at the next edge. No word is lost or duplicated.
- data_i capture: rx_valid=1 after the edge that samples data_i_valid.
- After reset deassertion, first RUN cycle follows SETTLE_CYCLES edges.
- Reset asserted mid-operation clears the FIFO, link outputs, and RX state asynchronously. Queued words are discarded and the FSM returns to SETTLE.

## Structure
- Package point_link_pkg holds the state enum (SETTLE, RUN) and a function computing the count width from DEPTH.
- Sub-module point_fifo: synchronous FIFO with parameters WIDTH, DEPTH and ports push, pop, din, dout, count, full, empty. It has the same asynchronous active-high reset.
- The top level contains the FSM, settle counter, data_o register, and RX holding register.

## Test plan
- Reset with SETTLE_CYCLES=4 and tx_valid=1: tx_ready=0 and stall_o=1 for 4 cycles, then tx_ready=1. data_i_valid pulses during settle do not set rx_valid.
- Push 0x11, 0x22, 0x33 back-to-back with stall_i=0: data_o shows 0x11, 0x22, 0x33 on consecutive cycles, starting 1 cycle after the first push, then data_o_valid→0.
- Hold stall_i=1 while pushing 5 words with DEPTH=4: data_o stays at word 1, tx_count reaches 4, and tx_ready=0. Releasing stall_i drains words 1–5 in order with none lost.
- Full FIFO with stall_i=0 and tx_valid=1: the push is refused on the pop cycle and accepted the next cycle. tx_count goes 4→3→4.
- rx_ready=0, then data_i=0xA5 valid followed by data_i=0x5A valid: rx_data=0xA5, stall_o=1, and rx_overflow=1. After rx_ready=1, rx_valid→0 and rx_overflow stays 1.
- Assert reset with 3 words queued and data_o_valid=1: all outputs go immediately to their reset values. After settle, no stale word appears on data_o.
